// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryptor: one cipher round per clock, valid/ready result handshake.
// Optional macro AES_KEY_LATCH_EN captures all round keys on accept; otherwise they are used live.
`timescale 1ns/1ps
module aes128_cipher_core #(
  parameter SBOX_FILE = "aes_sbox.mem"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] round_keys [0:10],
  input  logic [127:0] plaintext,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] ciphertext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] rk_sel;
  logic [127:0] round_out;
  logic         accept;

  logic [7:0] sbox_rom [0:255];
  logic [7:0] sb [0:15];
  logic [7:0] sr [0:15];
  logic [7:0] mc [0:15];
  logic [7:0] a0, a1, a2, a3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Forward S-box entry: multiplicative inverse (b^254, zero maps to zero) then the affine map.
  function automatic logic [7:0] sbox_entry(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] base;
    logic [7:0] r;
    logic [7:0] s;
    logic [7:0] e;
    inv  = 8'h01;
    base = b;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gf_mul(inv, base);
      base = gf_mul(base, base);
    end
    s = inv;
    r = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  // ROM contents are constant per address; SBOX_FILE names the equivalent preload image.
  for (genvar g = 0; g < 256; g++) begin : g_sbox
    assign sbox_rom[g] = sbox_entry(8'(g));
  end

  assign accept = in_valid && (fsm_q == S_IDLE);

`ifdef AES_KEY_LATCH_EN
  logic [127:0] key_bank_q [0:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) key_bank_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 11; i++) key_bank_q[i] <= round_keys[i];
    end
  end

  assign rk_sel = key_bank_q[round_q];
`else
  assign rk_sel = round_keys[round_q];
`endif

  // One full round: SubBytes -> ShiftRows -> MixColumns (skipped in round 10) -> AddRoundKey.
  always_comb begin
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    round_out = '0;
    for (int n = 0; n < 16; n++) sb[n] = sbox_rom[blk_q[127-8*n -: 8]];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int n = 0; n < 16; n++) begin
      round_out[127-8*n -: 8] = ((round_q == 4'd10) ? sr[n] : mc[n]) ^ rk_sel[127-8*n -: 8];
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    blk_d   = blk_q;
    ct_d    = ct_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_d   = plaintext ^ round_keys[0];
          round_d = 4'd1;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        blk_d = round_out;
        if (round_q == 4'd10) begin
          ct_d  = round_out;
          fsm_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      round_q <= 4'd0;
      blk_q   <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      ct_q    <= ct_d;
    end
  end

  // Handshake flags decode registered state only; rst masks in_ready while held.
  assign in_ready   = (fsm_q == S_IDLE) && !rst;
  assign busy       = (fsm_q == S_ROUND) || (fsm_q == S_DONE);
  assign out_valid  = (fsm_q == S_DONE);
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Scoreboard bench for aes128_cipher_core using the FIPS-197 App. B and App. C.1 vectors.
`timescale 1ns/1ps
module tb_aes128_cipher_core;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] round_keys [0:10];
  logic [127:0] plaintext = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;

  logic [127:0] keys_b [0:10];
  logic [127:0] keys_c [0:10];
  logic [127:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_last = -100;
  int acc_prev = -100;
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_cipher_core dut (
    .clk(clk), .rst(rst), .round_keys(round_keys), .plaintext(plaintext),
    .in_valid(in_valid), .in_ready(in_ready), .ciphertext(ciphertext),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse found by exhaustive search, then the affine transform.
  function automatic logic [7:0] tsbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    s = inv;
    r = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {tsbox(t[31:24]), tsbox(t[23:16]), tsbox(t[15:8]), tsbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic set_vec(input int sel);
    for (int r = 0; r < 11; r++) round_keys[r] = (sel != 0) ? keys_c[r] : keys_b[r];
    plaintext = (sel != 0) ? PT_C : PT_B;
  endtask

  // Present a block, wait (bounded) for accept, optionally record its expected result.
  task automatic run(input int sel, input bit push);
    int n;
    n = 0;
    set_vec(sel);
    in_valid = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 40) timeout("accept");
    @(posedge clk);
    if (push) exp_q.push_back((sel != 0) ? CT_C : CT_B);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    if (n >= 40) timeout("out_valid");
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks latency and handshake flags.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chkb("in_ready_vs_busy", in_ready, !busy);
        if (out_valid && !prev_ov) chki("latency", cyc - acc_last, 10);
        if (in_valid && in_ready) begin
          acc_prev = acc_last;
          acc_last = cyc + 1;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %h with empty scoreboard", ciphertext);
          end else begin
            chk("ciphertext", ciphertext, exp_q.pop_front());
          end
        end
      end
      prev_ov = out_valid && !rst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1407:0] e;
    int n;
    e = expand(KEY_B);
    for (int r = 0; r < 11; r++) keys_b[r] = e[1407-128*r -: 128];
    e = expand(KEY_C);
    for (int r = 0; r < 11; r++) keys_c[r] = e[1407-128*r -: 128];
    for (int r = 0; r < 11; r++) round_keys[r] = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_in_ready", in_ready, 1'b0);
    chk("rst_ciphertext", ciphertext, '0);
    rst = 1'b0;
    #1 chkb("in_ready_after_rst", in_ready, 1'b1);

    // App. B and App. C.1, single blocks
    run(0, 1'b1);
    wait_out_valid();
    run(1, 1'b1);
    wait_out_valid();

    // Back-to-back with in_valid held high; keys switch only after round 10 of the first block
    @(posedge clk);
    #1;
    set_vec(0);
    in_valid = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 40) timeout("b2b_first_accept");
    @(posedge clk);
    exp_q.push_back(CT_B);
    repeat (10) @(posedge clk);
    #1;
    set_vec(1);
    exp_q.push_back(CT_C);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 40) timeout("b2b_second_accept");
    @(posedge clk);
    #1 in_valid = 1'b0;
    chki("b2b_spacing", acc_last - acc_prev, 12);
    wait_out_valid();

    // Output stall for 20 cycles
    @(posedge clk);
    #1 out_ready = 1'b0;
    run(1, 1'b1);
    wait_out_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chkb("stall_out_valid", out_valid, 1'b1);
      chk("stall_ciphertext", ciphertext, CT_C);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chkb("post_stall_in_ready", in_ready, 1'b1);
    chkb("post_stall_out_valid", out_valid, 1'b0);

    // Reset asserted for one cycle at round 5
    run(0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chkb("rst_mid_in_ready_low", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chkb("rst_mid_out_valid", out_valid, 1'b0);
    chkb("rst_mid_busy", busy, 1'b0);
    chkb("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_ciphertext", ciphertext, '0);
    run(0, 1'b1);
    wait_out_valid();

`ifdef AES_KEY_LATCH_EN
    // Keys zeroed one cycle after accept must not disturb the result
    run(0, 1'b1);
    @(posedge clk);
    #1;
    for (int r = 0; r < 11; r++) round_keys[r] = '0;
    wait_out_valid();
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout("scoreboard_drain");
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
